// File: rtl/lfsr_pkg.sv
// Shared helpers and limits for the XNOR Fibonacci LFSR.
// Shift functions operate on a 32-bit container masked to width.
package lfsr_pkg;

  localparam int LFSR_MAX_W = 32;
  localparam int LFSR_MIN_W = 3;

  function automatic logic [LFSR_MAX_W-1:0] lfsr_shift(
    input logic [LFSR_MAX_W-1:0] state,
    input int                    width,
    input int                    tap_a,
    input int                    tap_b
  );
    logic                  fb;
    logic [LFSR_MAX_W-1:0] mask;
    logic [LFSR_MAX_W-1:0] res;
    fb = state[5'(tap_a-1)] ~^ state[5'(tap_b-1)];
    for (int i = 0; i < LFSR_MAX_W; i++)
      mask[i] = (i < width);
    res = {state[LFSR_MAX_W-2:0], fb} & mask;
    return res;
  endfunction

  function automatic logic [LFSR_MAX_W-1:0] lfsr_advance(
    input logic [LFSR_MAX_W-1:0] state,
    input int                    width,
    input int                    tap_a,
    input int                    tap_b,
    input int                    steps
  );
    logic [LFSR_MAX_W-1:0] s;
    s = state;
    for (int i = 0; i < LFSR_MAX_W; i++)
      if (i < steps)
        s = lfsr_shift(s, width, tap_a, tap_b);
    return s;
  endfunction

endpackage

// File: rtl/lfsr_prng.sv
// XNOR Fibonacci LFSR with seed load, multi-step advance,
// all-ones lock-up recovery and a registered threshold hit.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int TAP_A = 10,
  parameter int TAP_B = 7,
  parameter int STEPS = 1,
  parameter int CMP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [CMP_W-1:0] thresh,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             hit,
  output logic             lockup
);

  if (WIDTH < LFSR_MIN_W || WIDTH > LFSR_MAX_W) begin : g_bad_width
    $error("lfsr_prng: WIDTH out of range");
  end
  if (TAP_A != WIDTH) begin : g_bad_tap_a
    $error("lfsr_prng: TAP_A must equal WIDTH");
  end
  if (TAP_B < 1 || TAP_B >= WIDTH) begin : g_bad_tap_b
    $error("lfsr_prng: TAP_B out of range");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_prng: STEPS out of range");
  end
  if (CMP_W < 1 || CMP_W > WIDTH) begin : g_bad_cmp_w
    $error("lfsr_prng: CMP_W out of range");
  end

  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic             r_hit;
  logic             r_lockup;

  logic [WIDTH-1:0] w_next;
  logic             w_upd;
  logic             w_lock;

  // Next state: load beats en; all-ones is forced back to zero.
  always_comb begin
    w_next = r_out;
    w_lock = 1'b0;
    w_upd  = load | en;
    if (load) begin
      if (&seed) begin
        w_next = '0;
        w_lock = 1'b1;
      end else begin
        w_next = seed;
      end
    end else if (en) begin
      if (&r_out) begin
        w_next = '0;
        w_lock = 1'b1;
      end else begin
        w_next = WIDTH'(lfsr_advance(32'(r_out), WIDTH,
                                     TAP_A, TAP_B, STEPS));
      end
    end
  end

  // State and status registers; hit follows only updated states.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out    <= '0;
      r_valid  <= 1'b0;
      r_hit    <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      r_out    <= w_next;
      r_valid  <= w_upd;
      r_lockup <= w_lock;
      if (w_upd)
        r_hit <= (w_next[CMP_W-1:0] < thresh);
    end
  end

  assign out    = r_out;
  assign valid  = r_valid;
  assign hit    = r_hit;
  assign lockup = r_lockup;

endmodule

// File: tb/tb_lfsr_prng.sv
// Scoreboard bench for lfsr_prng: stimulus pushes expected
// results, a monitor pops them whenever valid is seen.
module tb_lfsr_prng;

  typedef struct {
    logic [9:0] out;
    logic       hit;
    logic       lk;
    int         id;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [9:0] seed;
  logic [3:0] thresh;
  logic [9:0] out;
  logic       valid;
  logic       hit;
  logic       lockup;

  logic       en2;
  logic [9:0] seed2;
  logic [3:0] thresh2;
  logic [9:0] out2;
  logic       valid2;
  logic       hit2;
  logic       lockup2;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  lfsr_prng #(
    .WIDTH(10), .TAP_A(10), .TAP_B(7), .STEPS(1), .CMP_W(4)
  ) u_dut (
    .clk(clk), .reset(reset), .en(en), .load(load),
    .seed(seed), .thresh(thresh), .out(out),
    .valid(valid), .hit(hit), .lockup(lockup)
  );

  lfsr_prng #(
    .WIDTH(10), .TAP_A(10), .TAP_B(7), .STEPS(2), .CMP_W(4)
  ) u_dut2 (
    .clk(clk), .reset(reset), .en(en2), .load(1'b0),
    .seed(seed2), .thresh(thresh2), .out(out2),
    .valid(valid2), .hit(hit2), .lockup(lockup2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [9:0] nxt(input logic [9:0] v);
    return {v[8:0], ~(v[9] ^ v[6])};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic l,
                       input logic [9:0] s, input logic [3:0] t);
    @(negedge clk);
    en = e; load = l; seed = s; thresh = t;
  endtask

  task automatic step(input logic e, input logic l,
                      input logic [9:0] s, input logic [3:0] t,
                      input logic [9:0] o, input logic h,
                      input logic lk, input int id);
    exp_t x;
    drive(e, l, s, t);
    x.out = o; x.hit = h; x.lk = lk; x.id = id;
    q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; en = 1'b0; load = 1'b0; en2 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every valid pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_valid out=%h", out);
        end else begin
          e = q.pop_front();
          if (out !== e.out || hit !== e.hit || lockup !== e.lk) begin
            errors++;
            $display("FAIL sb[%0d] got out=%h hit=%b lk=%b want out=%h hit=%b lk=%b",
                     e.id, out, hit, lockup, e.out, e.hit, e.lk);
          end
        end
      end
    end
  end

  logic [9:0] t1 [8];
  logic       seen [1024];
  logic [9:0] m;
  int         dups;
  int         ones;

  initial begin
    t1 = '{10'h001, 10'h003, 10'h007, 10'h00F,
           10'h01F, 10'h03F, 10'h07F, 10'h0FE};
    reset = 1'b1; en = 1'b1; load = 1'b1;
    seed = 10'h155; thresh = 4'd0;
    en2 = 1'b0; seed2 = '0; thresh2 = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_hit", 32'(hit), 32'h0);
    chk("rst_lockup", 32'(lockup), 32'h0);
    do_reset();

    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 0, t1[i], 0, 0, 100 + i);

    do_reset();
    m = 10'h000;
    dups = 0;
    ones = 0;
    for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
    for (int i = 0; i < 1023; i++) begin
      m = nxt(m);
      step(1, 0, 0, 0, (i == 1022) ? 10'h000 : m, 0, 0, 200);
      @(posedge clk);
      #2;
      if (seen[out]) dups++;
      seen[out] = 1'b1;
      if (out == 10'h3FF) ones++;
    end
    chk("period_end_out", 32'(out), 32'h000);
    chk("period_dups", 32'(dups), 32'h0);
    chk("period_allones", 32'(ones), 32'h0);

    step(0, 1, 10'h3FF, 4'd6, 10'h000, 1, 1, 300);
    drive(0, 0, 0, 4'd6);
    @(posedge clk);
    #2;
    chk("lock_pulse_end", 32'(lockup), 32'h0);
    chk("idle_valid", 32'(valid), 32'h0);
    chk("idle_hold_out", 32'(out), 32'h000);
    chk("idle_hold_hit", 32'(hit), 32'h1);
    step(1, 1, 10'h155, 4'd6, 10'h155, 1, 0, 301);
    step(1, 0, 0, 4'd6, 10'h2AA, 0, 0, 302);

    do_reset();
    step(1, 0, 0, 4'd4, 10'h001, 1, 0, 400);
    step(1, 0, 0, 4'd4, 10'h003, 1, 0, 401);
    step(1, 0, 0, 4'd4, 10'h007, 0, 0, 402);
    m = 10'h007;
    for (int i = 0; i < 50; i++) begin
      m = nxt(m);
      step(1, 0, 0, 4'd0, m, 0, 0, 403);
    end

    do_reset();
    @(negedge clk);
    en2 = 1'b1;
    @(posedge clk);
    #2;
    chk("steps2_first", 32'(out2), 32'h003);
    chk("steps2_valid", 32'(valid2), 32'h1);
    @(posedge clk);
    #2;
    chk("steps2_second", 32'(out2), 32'h00F);
    @(negedge clk);
    en2 = 1'b0;

    do_reset();
    m = 10'h000;
    for (int i = 0; i < 20; i++) begin
      m = nxt(m);
      step(1, 0, 0, 0, m, 0, 0, 600);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("midrst_out", 32'(out), 32'h000);
    chk("midrst_valid", 32'(valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    q.push_back('{out: t1[0], hit: 1'b0, lk: 1'b0, id: 601});
    for (int i = 1; i < 8; i++)
      step(1, 0, 0, 0, t1[i], 0, 0, 601 + i);

    drive(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
